// File: rtl/avl_pkg.sv
// Shared types and constants for the Avalon-MM master controller.
// Holds the controller state encoding and the abort read value.
package avl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [31:0] AVL_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/avl_timeout_ctr.sv
// Stall counter for the Avalon master; only built with AVL_MASTER_TIMEOUT_EN.
// Counts stalled ACCESS cycles and flags the one that reaches LIMIT.
`ifdef AVL_MASTER_TIMEOUT_EN
module avl_timeout_ctr #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt;

    // Count stalled cycles; cleared whenever the FSM is not in ACCESS
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The stalled cycle that would bring the count to LIMIT is the abort edge
    assign expired = en && (cnt == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/avl_master_ctrl.sv
// Single-transfer Avalon-MM master fed by a level-held bridge request.
// Optional stall timeout enabled by defining AVL_MASTER_TIMEOUT_EN.
module avl_master_ctrl #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_writedata,
    input  logic [3:0]  bus_byteenable,
    input  logic        bus_read,
    input  logic        bus_write,
    output logic [31:0] bus_readdata,
    output logic        bus_busy,
    output logic        bus_err,
    input  logic [31:0] avl_readdata,
    input  logic        avl_waitrequest,
    output logic [31:0] avl_address,
    output logic [3:0]  avl_byteenable,
    output logic [31:0] avl_writedata,
    output logic        avl_read,
    output logic        avl_write
);

    import avl_pkg::*;

    state_t      state;
    logic        op_rd;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q;
    logic        req_ok;
    logic        in_access;
    logic        timeout_hit;

    assign req_ok    = bus_read ^ bus_write;
    assign in_access = (state == ACCESS);

`ifdef AVL_MASTER_TIMEOUT_EN
    logic err_q;

    avl_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (!in_access),
        .en      (in_access && avl_waitrequest),
        .expired (timeout_hit)
    );

    // One-cycle error pulse, visible in DONE after an abort
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_hit;
        end
    end

    assign bus_err = err_q;
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_hit    = 1'b0;
    assign bus_err        = 1'b0;
`endif

    // Request latch, transfer sequencing and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op_rd   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'b1111;
            rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_ok) begin
                        op_rd   <= bus_read;
                        addr_q  <= bus_address;
                        wdata_q <= bus_writedata;
                        be_q    <= bus_byteenable;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!avl_waitrequest) begin
                        if (op_rd) begin
                            rdata_q <= avl_readdata;
                        end
                        state <= DONE;
                    end else if (timeout_hit) begin
                        if (op_rd) begin
                            rdata_q <= AVL_ERR_DATA;
                        end
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign avl_read       = in_access && op_rd;
    assign avl_write      = in_access && !op_rd;
    assign avl_address    = addr_q;
    assign avl_byteenable = be_q;
    assign avl_writedata  = wdata_q;
    assign bus_readdata   = rdata_q;
    assign bus_busy       = in_access || ((state == IDLE) && req_ok);

endmodule

// File: doc/avl_master_ctrl.md
AVL_MASTER_CTRL -- requirements
Module: avl_master_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256, is the number of waitrequest cycles in ACCESS before abort; used only when the timeout feature is compiled in.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 bus_address  input  32  request address from the Harvard bridge.
REQ-005 bus_writedata  input  32  request write data.
REQ-006 bus_byteenable  input  4  request byte lanes.
REQ-007 bus_read  input  1  read request, level, held by the bridge until it sees bus_busy low.
REQ-008 bus_write  input  1  write request, level, with the same hold rule as bus_read.
REQ-009 bus_readdata  output  32  registered read result.
REQ-010 bus_busy  output  1  transfer pending or in progress.
REQ-011 bus_err  output  1  one-cycle pulse when an access is aborted by timeout.
REQ-012 avl_readdata  input  32  Avalon slave read data.
REQ-013 avl_waitrequest  input  1  Avalon slave stall.
REQ-014 avl_address  output  32  Avalon address.
REQ-015 avl_byteenable  output  4  Avalon byte enables.
REQ-016 avl_writedata  output  32  Avalon write data.
REQ-017 avl_read  output  1  Avalon read strobe.
REQ-018 avl_write  output  1  Avalon write strobe.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-020 Valid request: exactly one of bus_read and bus_write is high; both high SHALL be ignored and treated as no request.
REQ-021 In IDLE, on a valid request, the block SHALL latch address, writedata, byteenable and operation at the clock edge, then move to ACCESS.
REQ-022 In ACCESS, avl_read/avl_write SHALL be driven from the latched operation, and avl_address/avl_byteenable/avl_writedata from the latched registers.
REQ-023 All Avalon outputs SHALL stay stable for as long as avl_waitrequest is high.
REQ-024 In ACCESS with avl_waitrequest low, the block SHALL complete the transfer at that edge and move to DONE; the minimum transfer is one ACCESS cycle.
REQ-025 On completion of a read, avl_readdata SHALL be captured into bus_readdata; writes SHALL leave bus_readdata unchanged.
REQ-026 avl_read and avl_write SHALL be low in IDLE and DONE and SHALL never be high together.
REQ-027 bus_busy SHALL equal (state==ACCESS) | (state==IDLE & valid request), so the bridge sees busy in the same cycle it raises a request.
REQ-028 In DONE, bus_busy SHALL be 0, and the FSM SHALL return to IDLE unconditionally after one cycle.
REQ-029 A request still held during DONE SHALL NOT restart an access until it is re-sampled in IDLE.
REQ-030 Changes on the bus_* request inputs during ACCESS SHALL have no effect.

Reset
REQ-031 While rst is high at an edge: state SHALL go to IDLE, avl_read/avl_write to 0, bus_readdata to 0, bus_err to 0, latched byteenable to 4'b1111, and other latched registers to 0.
REQ-032 rst asserted mid-ACCESS SHALL abandon the transfer; strobes SHALL be low from the following cycle and no data is captured.

Configuration
REQ-033 With AVL_MASTER_TIMEOUT_EN defined, a counter SHALL clear on entry to ACCESS and increment on every ACCESS cycle in which avl_waitrequest is high.
REQ-034 With AVL_MASTER_TIMEOUT_EN defined, on reaching TIMEOUT_CYCLES the block SHALL drop the strobes, pulse bus_err, and move to DONE.
REQ-035 With AVL_MASTER_TIMEOUT_EN defined, an aborted read SHALL load bus_readdata with 32'hDEADBEEF.
REQ-036 Without AVL_MASTER_TIMEOUT_EN, ACCESS SHALL wait indefinitely, bus_err SHALL be tied to 0, and no counter logic SHALL be present.

Structure
REQ-037 Package avl_pkg SHALL hold the state_t enum (IDLE, ACCESS, DONE) and the constant AVL_ERR_DATA = 32'hDEADBEEF.
REQ-038 The timeout counter SHALL be the sub-module avl_timeout_ctr (inputs clr, en; output expired), instantiated only under AVL_MASTER_TIMEOUT_EN.

Verification
REQ-039 Read of 0x0000_0010 with waitrequest low and avl_readdata=0x1234_5678: avl_read high for one cycle, bus_readdata=0x1234_5678, busy low in DONE.
REQ-040 Write 0xCAFE_F00D to 0x20 with byteenable 4'b0011 and waitrequest high for 3 cycles: Avalon outputs stable for 4 cycles, avl_write then drops, and bus_readdata is unchanged.
REQ-041 bus_read and bus_write both high: no strobe, bus_busy 0, state stays IDLE.
REQ-042 Bridge DATA→CLEAR→ISET sequence (read, one idle cycle, read): two distinct Avalon reads occur with no overlap and each captures its own data.
REQ-043 rst asserted in the second ACCESS cycle of a stalled read: strobes low the next cycle and bus_readdata is 0.
REQ-044 With AVL_MASTER_TIMEOUT_EN defined and TIMEOUT_CYCLES=4, waitrequest stuck high: bus_err pulses once after 4 cycles, bus_readdata=0xDEADBEEF, and the FSM returns to IDLE.
